// File: rtl/sb_pkg.sv
// Shared definitions for the sideband TX scheduler.
//   sb_state_e   : scheduler FSM states
//   sb_grant_e   : o_grant_src encodings (none / pattern / LTSM / response)
//   sb_arbitrate : IDLE-state winner selection
package sb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPattern,
    StIssue,
    StWaitBusy,
    StWaitDone,
    StGap
  } sb_state_e;

  typedef enum logic [1:0] {
    GrantNone    = 2'b00,
    GrantPattern = 2'b01,
    GrantLtsm    = 2'b10,
    GrantRsp     = 2'b11
  } sb_grant_e;

  // Pattern requests win outright. LTSM and queued responses share the
  // channel round-robin: on a tie, whichever was served last loses.
  function automatic sb_grant_e sb_arbitrate(input logic pattern_req,
                                             input logic ltsm_valid,
                                             input logic rsp_avail,
                                             input logic last_ltsm);
    if (pattern_req) return GrantPattern;
    if (ltsm_valid && rsp_avail) return last_ltsm ? GrantRsp : GrantLtsm;
    if (ltsm_valid) return GrantLtsm;
    if (rsp_avail) return GrantRsp;
    return GrantNone;
  endfunction

endpackage

// File: rtl/sb_rsp_fifo.sv
// Response-message ID queue for the sideband TX scheduler.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   push_i         : enqueue push_id_i (ignored when full)
//   push_id_i      : ID to enqueue
//   pop_i          : drop head entry (ignored when empty)
//   head_id_o      : ID at the head of the queue
//   empty_o/full_o : occupancy flags
module sb_rsp_fifo
  import sb_pkg::*;
#(
  parameter int unsigned ID_W  = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            push_i,
  input  logic [ID_W-1:0] push_id_i,
  input  logic            pop_i,
  output logic [ID_W-1:0] head_id_o,
  output logic            empty_o,
  output logic            full_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(DEPTH);

  logic [ID_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   count_q, count_d;
  logic            push_en, pop_en;

  assign full_o    = (count_q == DepthCnt);
  assign empty_o   = (count_q == '0);
  assign push_en   = push_i && !full_o;
  assign pop_en    = pop_i && !empty_o;
  assign head_id_o = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop_en)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({push_en, pop_en})
      2'b10:   count_d = count_q + (PtrW + 1)'(1);
      2'b01:   count_d = count_q - (PtrW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while count_q says valid.
  always_ff @(posedge i_clk) begin
    if (push_en) mem_q[wr_ptr_q] <= push_id_i;
  end

endmodule

// File: rtl/sb_tx_scheduler.sv
// Sideband TX scheduler: arbitrates SBINIT pattern requests, LTSM messages
// and queued responses onto a single sideband TX FSM, one at a time, with
// at least one idle cycle between requests.
// Ports:
//   i_clk, i_rst_n                 : clock, asynchronous active-low reset
//   i_pattern_req                  : SBINIT pattern request (level)
//   i_ltsm_valid/id/has_data/data  : pending LTSM message, acked by o_ltsm_ack
//   i_rsp_valid/o_rsp_ready/i_rsp_id : response-queue push handshake
//   i_fsm_busy, i_fsm_pattern_done : TX FSM status
//   o_start_pattern_req            : pattern request to TX FSM
//   o_msg_valid/o_msg_id           : message request to TX FSM
//   o_data_valid/o_data            : payload accompanying o_msg_valid
//   o_ltsm_ack, o_pattern_done, o_err : single-cycle pulses
//   o_grant_src                    : source currently being served
module sb_tx_scheduler
  import sb_pkg::*;
#(
  parameter int unsigned ID_W      = 8,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned RSP_DEPTH = 2,
  parameter int unsigned BUSY_TO   = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_pattern_req,
  input  logic              i_ltsm_valid,
  input  logic [ID_W-1:0]   i_ltsm_id,
  input  logic              i_ltsm_has_data,
  input  logic [DATA_W-1:0] i_ltsm_data,
  input  logic              i_rsp_valid,
  output logic              o_rsp_ready,
  input  logic [ID_W-1:0]   i_rsp_id,
  input  logic              i_fsm_busy,
  input  logic              i_fsm_pattern_done,
  output logic              o_start_pattern_req,
  output logic              o_msg_valid,
  output logic              o_data_valid,
  output logic [ID_W-1:0]   o_msg_id,
  output logic [DATA_W-1:0] o_data,
  output logic              o_ltsm_ack,
  output logic              o_pattern_done,
  output logic              o_err,
  output logic [1:0]        o_grant_src
);

  localparam int unsigned ToW = $clog2(BUSY_TO + 1);

  sb_state_e         state_q, state_d;
  sb_grant_e         src_q, src_d;
  sb_grant_e         win;
  logic [ID_W-1:0]   msg_id_q, msg_id_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              has_data_q, has_data_d;
  logic              last_ltsm_q, last_ltsm_d;
  logic [ToW-1:0]    to_cnt_q, to_cnt_d;
  logic              to_expired;

  logic              rsp_push, rsp_pop;
  logic              rsp_empty, rsp_full;
  logic [ID_W-1:0]   rsp_head_id;

  assign o_rsp_ready = !rsp_full;
  assign rsp_push    = i_rsp_valid && o_rsp_ready;

  sb_rsp_fifo #(
    .ID_W  (ID_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .push_i    (rsp_push),
    .push_id_i (i_rsp_id),
    .pop_i     (rsp_pop),
    .head_id_o (rsp_head_id),
    .empty_o   (rsp_empty),
    .full_o    (rsp_full)
  );

  assign win        = sb_arbitrate(i_pattern_req, i_ltsm_valid, !rsp_empty, last_ltsm_q);
  // BUSY_TO-th consecutive WAIT_BUSY cycle with busy still low.
  assign to_expired = !i_fsm_busy && (to_cnt_q == ToW'(BUSY_TO - 1));

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      src_q       <= GrantNone;
      msg_id_q    <= '0;
      data_q      <= '0;
      has_data_q  <= 1'b0;
      last_ltsm_q <= 1'b0;
      to_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      msg_id_q    <= msg_id_d;
      data_q      <= data_d;
      has_data_q  <= has_data_d;
      last_ltsm_q <= last_ltsm_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  // Next-state logic. Message content is captured when the winner is chosen,
  // so o_msg_id/o_data change on entry to ISSUE and hold until the next one.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    msg_id_d    = msg_id_q;
    data_d      = data_q;
    has_data_d  = has_data_q;
    last_ltsm_d = last_ltsm_q;
    to_cnt_d    = to_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (win != GrantNone) begin
          src_d   = win;
          state_d = (win == GrantPattern) ? StPattern : StIssue;
        end
        if (win == GrantLtsm) begin
          msg_id_d   = i_ltsm_id;
          data_d     = i_ltsm_data;
          has_data_d = i_ltsm_has_data;
        end else if (win == GrantRsp) begin
          msg_id_d   = rsp_head_id;
          data_d     = '0;
          has_data_d = 1'b0;
        end
      end
      StPattern: begin
        // Exit only on the done pulse; a dropped request is ignored.
        if (i_fsm_pattern_done) state_d = StGap;
      end
      StIssue: begin
        last_ltsm_d = (src_q == GrantLtsm);
        to_cnt_d    = '0;
        state_d     = StWaitBusy;
      end
      StWaitBusy: begin
        if (i_fsm_busy) begin
          state_d = StWaitDone;
        end else if (to_expired) begin
          state_d = StGap;
        end else begin
          to_cnt_d = to_cnt_q + ToW'(1);
        end
      end
      StWaitDone: begin
        if (!i_fsm_busy) state_d = StGap;
      end
      StGap: begin
        src_d   = GrantNone;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    o_start_pattern_req = 1'b0;
    o_pattern_done      = 1'b0;
    o_msg_valid         = 1'b0;
    o_data_valid        = 1'b0;
    o_ltsm_ack          = 1'b0;
    o_err               = 1'b0;
    o_grant_src         = GrantNone;
    rsp_pop             = 1'b0;
    unique case (state_q)
      StPattern: begin
        o_start_pattern_req = 1'b1;
        o_pattern_done      = i_fsm_pattern_done;
        o_grant_src         = src_q;
      end
      StIssue: begin
        o_msg_valid  = 1'b1;
        o_data_valid = (src_q == GrantLtsm) && has_data_q;
        o_ltsm_ack   = (src_q == GrantLtsm);
        rsp_pop      = (src_q == GrantRsp);
        o_grant_src  = src_q;
      end
      StWaitBusy: begin
        o_err       = to_expired;
        o_grant_src = src_q;
      end
      StWaitDone: o_grant_src = src_q;
      default: ;
    endcase
  end

  assign o_msg_id = msg_id_q;
  assign o_data   = data_q;

endmodule

// File: tb/tb_sb_tx_scheduler.sv
// Bench for sb_tx_scheduler: directed scenarios followed by randomized rounds,
// checked against a transaction-level model (pending LTSM, response queue,
// last-served source).
module tb_sb_tx_scheduler;

  localparam int unsigned ID_W      = 8;
  localparam int unsigned DATA_W    = 64;
  localparam int unsigned RSP_DEPTH = 2;
  localparam int unsigned BUSY_TO   = 4;

  logic              i_clk = 1'b0;
  logic              i_rst_n;
  logic              i_pattern_req;
  logic              i_ltsm_valid;
  logic [ID_W-1:0]   i_ltsm_id;
  logic              i_ltsm_has_data;
  logic [DATA_W-1:0] i_ltsm_data;
  logic              i_rsp_valid;
  logic              o_rsp_ready;
  logic [ID_W-1:0]   i_rsp_id;
  logic              i_fsm_busy;
  logic              i_fsm_pattern_done;
  logic              o_start_pattern_req;
  logic              o_msg_valid;
  logic              o_data_valid;
  logic [ID_W-1:0]   o_msg_id;
  logic [DATA_W-1:0] o_data;
  logic              o_ltsm_ack;
  logic              o_pattern_done;
  logic              o_err;
  logic [1:0]        o_grant_src;

  sb_tx_scheduler #(
    .ID_W      (ID_W),
    .DATA_W    (DATA_W),
    .RSP_DEPTH (RSP_DEPTH),
    .BUSY_TO   (BUSY_TO)
  ) dut (
    .i_clk               (i_clk),
    .i_rst_n             (i_rst_n),
    .i_pattern_req       (i_pattern_req),
    .i_ltsm_valid        (i_ltsm_valid),
    .i_ltsm_id           (i_ltsm_id),
    .i_ltsm_has_data     (i_ltsm_has_data),
    .i_ltsm_data         (i_ltsm_data),
    .i_rsp_valid         (i_rsp_valid),
    .o_rsp_ready         (o_rsp_ready),
    .i_rsp_id            (i_rsp_id),
    .i_fsm_busy          (i_fsm_busy),
    .i_fsm_pattern_done  (i_fsm_pattern_done),
    .o_start_pattern_req (o_start_pattern_req),
    .o_msg_valid         (o_msg_valid),
    .o_data_valid        (o_data_valid),
    .o_msg_id            (o_msg_id),
    .o_data              (o_data),
    .o_ltsm_ack          (o_ltsm_ack),
    .o_pattern_done      (o_pattern_done),
    .o_err               (o_err),
    .o_grant_src         (o_grant_src)
  );

  always #5 i_clk = ~i_clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  logic [ID_W-1:0]   rsp_q[$];
  bit                ltsm_pend;
  logic [ID_W-1:0]   m_lid;
  bit                m_lhas;
  logic [DATA_W-1:0] m_ldata;
  bit                last_ltsm;  // last served was LTSM; starts 0 so LTSM wins first tie

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outs(input string p);
    chk({p, "_start"}, o_start_pattern_req, 1'b0);
    chk({p, "_mvalid"}, o_msg_valid, 1'b0);
    chk({p, "_dvalid"}, o_data_valid, 1'b0);
    chk({p, "_id"}, o_msg_id, '0);
    chk({p, "_data"}, o_data, '0);
    chk({p, "_ack"}, o_ltsm_ack, 1'b0);
    chk({p, "_pdone"}, o_pattern_done, 1'b0);
    chk({p, "_err"}, o_err, 1'b0);
    chk({p, "_src"}, o_grant_src, 2'b00);
    chk({p, "_ready"}, o_rsp_ready, 1'b1);
  endtask

  // One round: pattern (with optional LTSM raised alongside it), responses
  // loaded while the pattern runs, then every pending message served.
  task automatic do_round(input int n_rsp, input bit has_ltsm, input logic [ID_W-1:0] lid,
                          input bit lhas, input logic [DATA_W-1:0] ldata,
                          input logic [ID_W-1:0] rid0, input int to_mask,
                          input bit push_late, input logic [ID_W-1:0] late_id);
    int n, idx, d, h;
    bit late_done, win_ltsm, rdy;
    logic [1:0] exp_src;
    @(negedge i_clk);
    i_pattern_req = 1'b1;
    if (has_ltsm) begin
      i_ltsm_valid = 1'b1; i_ltsm_id = lid; i_ltsm_has_data = lhas; i_ltsm_data = ldata;
      ltsm_pend = 1'b1; m_lid = lid; m_lhas = lhas; m_ldata = ldata;
    end
    #1;
    n = 0;
    while (o_start_pattern_req !== 1'b1 && n < 8) begin @(negedge i_clk); #1; n++; end
    chk("pat_start", o_start_pattern_req, 1'b1);
    chk("pat_src", o_grant_src, 2'b01);
    chk("pat_no_msg", o_msg_valid, 1'b0);
    i_pattern_req = 1'b0;
    for (int k = 0; k < n_rsp; k++) begin
      @(negedge i_clk);
      i_rsp_valid = 1'b1;
      i_rsp_id = rid0 + ID_W'(k);
      #1;
      rdy = (rsp_q.size() < RSP_DEPTH);
      chk("push_ready", o_rsp_ready, rdy);
      if (rdy) rsp_q.push_back(i_rsp_id);
    end
    @(negedge i_clk);
    i_rsp_valid = 1'b0;
    i_fsm_pattern_done = 1'b1;
    #1;
    chk("rdy_loaded", o_rsp_ready, rsp_q.size() < RSP_DEPTH);
    chk("pat_held", o_start_pattern_req, 1'b1);
    chk("pat_done", o_pattern_done, 1'b1);
    @(negedge i_clk);
    i_fsm_pattern_done = 1'b0;
    #1;
    chk("gap_src", o_grant_src, 2'b00);
    chk("gap_start", o_start_pattern_req, 1'b0);
    chk("gap_pdone", o_pattern_done, 1'b0);

    idx = 0;
    late_done = 1'b0;
    while ((ltsm_pend || rsp_q.size() != 0) && idx < 16) begin
      win_ltsm = ltsm_pend && (rsp_q.size() == 0 || !last_ltsm);
      exp_src  = win_ltsm ? 2'b10 : 2'b11;
      n = 0;
      @(negedge i_clk); #1;
      while (o_msg_valid !== 1'b1 && n < 8) begin @(negedge i_clk); #1; n++; end
      chk("issue_seen", o_msg_valid, 1'b1);
      if (o_msg_valid !== 1'b1) return;
      chk("issue_src", o_grant_src, exp_src);
      chk("issue_id", o_msg_id, win_ltsm ? m_lid : rsp_q[0]);
      chk("issue_dvalid", o_data_valid, win_ltsm && m_lhas);
      chk("issue_ack", o_ltsm_ack, win_ltsm);
      if (win_ltsm) chk("issue_data", o_data, m_ldata);
      last_ltsm = win_ltsm;
      rdy = (rsp_q.size() < RSP_DEPTH);
      if (win_ltsm) ltsm_pend = 1'b0;
      else void'(rsp_q.pop_front());
      if (push_late && !win_ltsm && !late_done) begin
        late_done = 1'b1;
        chk("late_ready", o_rsp_ready, rdy);
        i_rsp_valid = 1'b1;
        i_rsp_id = late_id;
        if (rdy) rsp_q.push_back(late_id);
      end
      @(negedge i_clk);
      i_rsp_valid = 1'b0;
      if (win_ltsm) i_ltsm_valid = 1'b0;
      #1;
      chk("rdy_after_issue", o_rsp_ready, rsp_q.size() < RSP_DEPTH);
      chk("wb_src", o_grant_src, exp_src);
      chk("wb_ack", o_ltsm_ack, 1'b0);
      chk("wb_mvalid", o_msg_valid, 1'b0);
      if (to_mask[idx]) begin
        for (int j = 1; j <= int'(BUSY_TO); j++) begin
          if (j > 1) begin @(negedge i_clk); #1; end
          chk("to_err", o_err, j == int'(BUSY_TO));
        end
        @(negedge i_clk); #1;
        chk("to_gap_src", o_grant_src, 2'b00);
        chk("to_err_clr", o_err, 1'b0);
      end else begin
        d = $urandom_range(0, BUSY_TO - 2);
        for (int j = 0; j <= d; j++) begin
          if (j > 0) begin @(negedge i_clk); #1; end
          chk("wb_no_err", o_err, 1'b0);
        end
        i_fsm_busy = 1'b1;
        h = $urandom_range(1, 3);
        for (int j = 0; j < h; j++) begin
          @(negedge i_clk); #1;
          chk("wd_src", o_grant_src, exp_src);
          chk("wd_no_err", o_err, 1'b0);
        end
        @(negedge i_clk);
        i_fsm_busy = 1'b0;
        #1;
        chk("wd_src_end", o_grant_src, exp_src);
        @(negedge i_clk); #1;
        chk("done_gap_src", o_grant_src, 2'b00);
      end
      idx++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    i_rst_n = 1'b0; i_pattern_req = 1'b0; i_ltsm_valid = 1'b0; i_ltsm_id = '0;
    i_ltsm_has_data = 1'b0; i_ltsm_data = '0; i_rsp_valid = 1'b0; i_rsp_id = '0;
    i_fsm_busy = 1'b0; i_fsm_pattern_done = 1'b0;
    ltsm_pend = 1'b0; last_ltsm = 1'b0; m_lid = '0; m_lhas = 1'b0; m_ldata = '0;
    repeat (2) @(negedge i_clk);
    #1;
    chk_reset_outs("reset");
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Round-robin with pattern priority: issue order 0x12, 0xA1, 0xA2.
    do_round(2, 1'b1, 8'h12, 1'b0, 64'h0, 8'hA1, 0, 1'b0, 8'h00);
    // LTSM with payload.
    do_round(0, 1'b1, 8'h30, 1'b1, 64'hDEAD_BEEF, 8'h00, 0, 1'b0, 8'h00);
    // Busy never rises: o_err BUSY_TO cycles after ISSUE.
    do_round(0, 1'b1, 8'h41, 1'b0, 64'h0, 8'h00, 1, 1'b0, 8'h00);
    // Queue full: third push refused, push during full-queue pop refused.
    do_round(3, 1'b0, 8'h00, 1'b0, 64'h0, 8'hB1, 0, 1'b1, 8'hBF);
    // Same-cycle push/pop with one entry queued keeps count at one.
    do_round(1, 1'b0, 8'h00, 1'b0, 64'h0, 8'hC1, 0, 1'b1, 8'hC2);

    for (int r = 0; r < 40; r++) begin
      do_round($urandom_range(0, 3), 1'($urandom_range(0, 1)), ID_W'($urandom),
               1'($urandom_range(0, 1)), {$urandom, $urandom}, ID_W'($urandom),
               int'($urandom & $urandom), 1'($urandom_range(0, 1)), ID_W'($urandom));
    end

    // Reset while in WAIT_DONE with a response queued.
    @(negedge i_clk);
    i_ltsm_valid = 1'b1; i_ltsm_id = 8'h5A; i_ltsm_has_data = 1'b1; i_ltsm_data = 64'h1234;
    #1;
    n = 0;
    while (o_msg_valid !== 1'b1 && n < 8) begin @(negedge i_clk); #1; n++; end
    chk("rst_issue", o_msg_valid, 1'b1);
    @(negedge i_clk);
    i_ltsm_valid = 1'b0;
    i_fsm_busy = 1'b1;
    @(negedge i_clk);
    i_rsp_valid = 1'b1;
    i_rsp_id = 8'h77;
    #1;
    chk("rst_wd_src", o_grant_src, 2'b10);
    @(negedge i_clk);
    i_rsp_valid = 1'b0;
    #3;
    i_rst_n = 1'b0;
    #1;
    chk_reset_outs("rst_mid");
    rsp_q.delete(); ltsm_pend = 1'b0; last_ltsm = 1'b0;
    @(negedge i_clk);
    i_fsm_busy = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge i_clk); #1;
      chk("post_rst_mvalid", o_msg_valid, 1'b0);
      chk("post_rst_ack", o_ltsm_ack, 1'b0);
      chk("post_rst_err", o_err, 1'b0);
      chk("post_rst_src", o_grant_src, 2'b00);
      chk("post_rst_ready", o_rsp_ready, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
